// File: rtl/rvfi_mem_latency_bounder.sv
// Multi-channel bounded-latency memory responder for el2_veer harnesses.
// Each channel accepts one request, stalls 0..MAX_WAIT cycles, then returns rand_data.
module rvfi_mem_latency_bounder #(
    parameter int NCH      = 2,
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic [NCH-1:0]        req_valid,
    output logic [NCH-1:0]        req_ready,
    input  logic [NCH-1:0]        rand_stall,
    input  logic [NCH*DATA_W-1:0] rand_data,
    output logic [NCH-1:0]        rsp_valid,
    output logic [NCH*DATA_W-1:0] rsp_data,
    input  logic [NCH-1:0]        rsp_ready,
    input  logic                  flush,
    output logic [NCH*CNT_W-1:0]  wait_cnt,
    output logic [NCH-1:0]        bound_hit
);

    // state   | meaning
    // IDLE    | ready to accept a request
    // WAIT    | request held, inserting random stalls (cnt counts them)
    // RESP    | response presented, waiting for rsp_ready
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_t             state, state_nxt;
        logic [CNT_W-1:0]   cnt, cnt_nxt;
        logic [DATA_W-1:0]  data, data_nxt;
        logic               hit, hit_nxt;

        always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l) begin
                state <= ST_IDLE;
                cnt   <= '0;
                data  <= '0;
                hit   <= 1'b0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
                data  <= data_nxt;
                hit   <= hit_nxt;
            end
        end

        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            data_nxt  = data;
            hit_nxt   = hit;
            // flush wins over everything but leaves the sticky hit flag alone
            if (flush) begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (req_valid[i]) begin
                            state_nxt = ST_WAIT;
                            cnt_nxt   = '0;
                        end
                    end
                    ST_WAIT: begin
                        if (rand_stall[i] && (cnt < CNT_MAX)) begin
                            cnt_nxt = cnt + 1'b1;
                        end else begin
                            state_nxt = ST_RESP;
                            cnt_nxt   = '0;
                            data_nxt  = rand_data[i*DATA_W +: DATA_W];
                            if (rand_stall[i]) hit_nxt = 1'b1;
                        end
                    end
                    ST_RESP: begin
                        if (rsp_ready[i]) begin
                            state_nxt = ST_IDLE;
                            cnt_nxt   = '0;
                        end
                    end
                    default: begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end
                endcase
            end
        end

        assign req_ready[i]                    = (state == ST_IDLE) && !flush;
        assign rsp_valid[i]                    = (state == ST_RESP);
        assign rsp_data[i*DATA_W +: DATA_W]    = data;
        assign wait_cnt[i*CNT_W +: CNT_W]      = cnt;
        assign bound_hit[i]                    = hit;
    end

endmodule
